// File: rtl/wind_mode_scheduler.sv
// wind_mode_scheduler
//   Sequencing controller for the hazard_lights datapath. Produces a one-cycle
//   step enable every TICK_DIV clocks, a pattern phase index within the frame,
//   and a debounced wind mode that is only committed at a frame boundary.
//
//   Optional feature macro: WMS_SPEEDUP_EN
//     defined   : speed==1 moves the wrap point to TICK_DIV/2-1 (double step rate)
//     undefined : speed is ignored, wrap point is always TICK_DIV-1
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   wind[1:0]    in   raw switch: 00 calm, 01 R->L, 10 L->R, 11 illegal
//   pause        in   level, freezes stepping and candidate tracking
//   speed        in   double-rate request (WMS_SPEEDUP_EN builds only)
//   step         out  one-cycle step enable
//   mode[1:0]    out  committed wind mode
//   phase[1:0]   out  pattern index within the frame
//   frame_start  out  high with the step that returns phase to 0
//   pending      out  debounced new mode waiting for the frame end
module wind_mode_scheduler #(
    parameter int TICK_DIV     = 25_000_000,
    parameter int STABLE_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] wind,
    input  logic       pause,
    input  logic       speed,
    output logic       step,
    output logic [1:0] mode,
    output logic [1:0] phase,
    output logic       frame_start,
    output logic       pending
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST_FULL  = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          resume_pend_q, resume_pend_d;  // state to return to after HOLD
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    cand_q, cand_d;
    logic [SW-1:0] cand_cnt_q, cand_cnt_d;
    logic [1:0]    wind_m_q, wind_m_d;            // synchronizer first stage
    logic [1:0]    wind_s_q, wind_s_d;            // synchronized wind

    logic [CW-1:0] wrap_pt;
    logic [1:0]    last_phase;
    logic          frozen;

`ifdef WMS_SPEEDUP_EN
    localparam logic [CW-1:0] LAST_HALF = CW'(TICK_DIV / 2 - 1);
    // When speed rises with div_cnt already past the half wrap point, the
    // ">=" compare below sends the counter to 0 without producing a step.
    assign wrap_pt = speed ? LAST_HALF : LAST_FULL;
`else
    logic unused_speed;
    assign unused_speed = speed;
    assign wrap_pt      = LAST_FULL;
`endif

    always_comb begin
        state_d       = state_q;
        resume_pend_d = resume_pend_q;
        div_cnt_d     = div_cnt_q;
        phase_d       = phase_q;
        mode_d        = mode_q;
        cand_d        = cand_q;
        cand_cnt_d    = cand_cnt_q;
        wind_m_d      = wind;
        wind_s_d      = wind_m_q;

        // pause blocks a coincident step immediately, before HOLD is registered;
        // the HOLD state keeps everything frozen for the cycle pause drops.
        frozen      = (state_q == ST_HOLD) || pause;
        last_phase  = (mode_q == 2'b00) ? 2'd1 : 2'd2;
        step        = (div_cnt_q == wrap_pt) && !frozen;
        frame_start = step && (phase_q == last_phase);
        pending     = (state_q == ST_PEND) || ((state_q == ST_HOLD) && resume_pend_q);

        if (!frozen)
            div_cnt_d = (div_cnt_q >= wrap_pt) ? '0 : div_cnt_q + CW'(1);
        if (step)
            phase_d = frame_start ? 2'd0 : phase_q + 2'd1;

        case (state_q)
            ST_RUN: begin
                if (pause) begin
                    state_d       = ST_HOLD;
                    resume_pend_d = 1'b0;
                end else if ((wind_s_q == mode_q) || (wind_s_q == 2'b11)) begin
                    cand_cnt_d = '0;
                end else if (wind_s_q != cand_q) begin
                    cand_d     = wind_s_q;
                    cand_cnt_d = '0;
                end else if (step) begin
                    if (cand_cnt_q != STABLE_MAX)
                        cand_cnt_d = cand_cnt_q + SW'(1);
                    if (cand_cnt_d == STABLE_MAX)
                        state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // A wind change beats a coincident frame_start: nothing commits.
                if (pause) begin
                    state_d       = ST_HOLD;
                    resume_pend_d = 1'b1;
                end else if (wind_s_q != cand_q) begin
                    state_d    = ST_RUN;
                    cand_cnt_d = '0;
                end else if (frame_start) begin
                    mode_d     = cand_q;
                    cand_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (!pause)
                    state_d = resume_pend_q ? ST_PEND : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            resume_pend_q <= 1'b0;
            div_cnt_q     <= '0;
            phase_q       <= '0;
            mode_q        <= '0;
            cand_q        <= '0;
            cand_cnt_q    <= '0;
            wind_m_q      <= '0;
            wind_s_q      <= '0;
        end else begin
            state_q       <= state_d;
            resume_pend_q <= resume_pend_d;
            div_cnt_q     <= div_cnt_d;
            phase_q       <= phase_d;
            mode_q        <= mode_d;
            cand_q        <= cand_d;
            cand_cnt_q    <= cand_cnt_d;
            wind_m_q      <= wind_m_d;
            wind_s_q      <= wind_s_d;
        end
    end

    assign mode  = mode_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_wind_mode_scheduler.sv
// Randomized bench for wind_mode_scheduler (TICK_DIV=4, STABLE_TICKS=2) with a
// cycle-level reference model of the frame/debounce rules.
module tb_wind_mode_scheduler;

    localparam int TD = 4;
    localparam int ST = 2;
`ifdef WMS_SPEEDUP_EN
    localparam bit SPD_EN = 1'b1;
`else
    localparam bit SPD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] wind;
    logic       pause;
    logic       speed;
    logic       step;
    logic [1:0] mode;
    logic [1:0] phase;
    logic       frame_start;
    logic       pending;

    always #5 clk = ~clk;

    wind_mode_scheduler #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk(clk), .reset(reset), .wind(wind), .pause(pause), .speed(speed),
        .step(step), .mode(mode), .phase(phase),
        .frame_start(frame_start), .pending(pending)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_cnt, m_phase, m_mode, m_cand, m_stab;
    bit m_pend, m_held;
    int m_sync[2];

    function automatic int m_len();
        return (m_mode == 0) ? 2 : 3;
    endfunction

    function automatic int m_wrap();
        return (SPD_EN && speed) ? TD / 2 - 1 : TD - 1;
    endfunction

    function automatic bit m_step();
        return !(m_held || pause) && (m_cnt == m_wrap());
    endfunction

    function automatic bit m_frame();
        return m_step() && (m_phase == m_len() - 1);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_mode = 0; m_cand = 0; m_stab = 0;
        m_pend = 0; m_held = 0; m_sync[0] = 0; m_sync[1] = 0;
    endtask

    task automatic model_edge();
        bit st, fr;
        int ws;
        st = m_step();
        fr = m_frame();
        ws = m_sync[1];
        if (!(m_held || pause)) begin
            m_cnt = (m_cnt >= m_wrap()) ? 0 : m_cnt + 1;
            if (st) m_phase = fr ? 0 : m_phase + 1;
            if (m_pend) begin
                if (ws != m_cand) begin
                    m_pend = 0; m_stab = 0;
                end else if (fr) begin
                    m_mode = m_cand; m_pend = 0; m_stab = 0;
                end
            end else begin
                if (ws == m_mode || ws == 3) m_stab = 0;
                else if (ws != m_cand) begin
                    m_cand = ws; m_stab = 0;
                end else if (st) begin
                    if (m_stab < ST) m_stab++;
                    if (m_stab == ST) m_pend = 1;
                end
            end
        end
        m_held    = pause;
        m_sync[1] = m_sync[0];
        m_sync[0] = int'(wind);
    endtask

    // One clock: drive just after the falling edge, check, advance the model
    // for the coming rising edge, then wait for the next falling edge.
    task automatic cycle(input logic [1:0] w, input logic p, input logic s);
        wind = w; pause = p; speed = s;
        #1;
        chk("step",        32'(step),        32'(m_step()));
        chk("frame_start", 32'(frame_start), 32'(m_frame()));
        chk("pending",     32'(pending),     32'(m_pend));
        chk("mode",        32'(mode),        32'(m_mode));
        chk("phase",       32'(phase),       32'(m_phase));
        if (reset) model_edge();
        else       model_reset();
        @(negedge clk);
    endtask

    task automatic async_reset_check(input string tag);
        reset = 1'b0;
        model_reset();
        #2;
        chk({tag, "_step"},    32'(step),        32'd0);
        chk({tag, "_frame"},   32'(frame_start), 32'd0);
        chk({tag, "_pending"}, 32'(pending),     32'd0);
        chk({tag, "_mode"},    32'(mode),        32'd0);
        chk({tag, "_phase"},   32'(phase),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_step;
        int rem_pause;
        bit hit;
        logic [1:0] w;
        logic p, s;

        reset = 1'b0; wind = 2'b00; pause = 1'b0; speed = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_step",    32'(step),        32'd0);
        chk("rst_frame",   32'(frame_start), 32'd0);
        chk("rst_pending", 32'(pending),     32'd0);
        chk("rst_mode",    32'(mode),        32'd0);
        chk("rst_phase",   32'(phase),       32'd0);
        reset = 1'b1;

        // calm: first step on the 4th edge after release, LEN=2 frames
        first_step = 0;
        for (int i = 1; i <= 12; i++) begin
            if (step === 1'b1 && first_step == 0) first_step = i;
            cycle(2'b00, 1'b0, 1'b0);
        end
        chk("first_step_clk", 32'(first_step), 32'd4);

        // R->L held long enough to commit, then LEN=3 frames
        for (int i = 0; i < 48; i++) cycle(2'b01, 1'b0, 1'b0);
        chk("mode_commit_01", 32'(mode), 32'd1);

        // abandoned candidate: 10 becomes pending, then wind drops to 11
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle(2'b10, 1'b0, 1'b0);
            hit = m_pend;
        end
        chk("reach_pend_10", 32'(hit), 32'd1);
        for (int i = 0; i < 30; i++) cycle(2'b11, 1'b0, 1'b0);
        chk("illegal_keeps_mode", 32'(mode), 32'd1);

        // pause for 10 clocks mid-count
        for (int i = 0; i < 5; i++) cycle(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(2'b01, 1'b0, 1'b0);

        // speed request
        for (int i = 0; i < 20; i++) cycle(2'b01, 1'b0, 1'b1);

        // get to mode 10, then a pending 01 with phase 2, then async reset
        for (int i = 0; i < 60; i++) cycle(2'b10, 1'b0, 1'b0);
        chk("mode_commit_10", 32'(mode), 32'd2);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cycle(2'b01, 1'b0, 1'b0);
            hit = m_pend && (m_phase == 2) && (m_mode == 2);
        end
        chk("reach_pend_ph2", 32'(hit), 32'd1);
        async_reset_check("async_rst");
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        reset = 1'b1;

        // randomized traffic
        w = 2'b00; p = 1'b0; s = 1'b0; rem_pause = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) w = 2'($urandom_range(0, 3));
            if (rem_pause > 0) begin
                p = 1'b1; rem_pause--;
            end else begin
                p = 1'b0;
                if ($urandom_range(0, 59) == 0) rem_pause = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 49) == 0) s = ~s;
            if ($urandom_range(0, 699) == 0) begin
                async_reset_check("rand_rst");
                cycle(w, p, s);
                reset = 1'b1;
            end else begin
                cycle(w, p, s);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
